// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed 4-digit 7-segment bus,
// debounces each digit, decodes it to BCD and publishes full frames.
module seg7_scan_reader #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_sel,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        timeout
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
    localparam logic [SW-1:0] STAB_HIT = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    logic [10:0]   samp_q;
    logic [10:0]   prev_q;
    logic [SW-1:0] stab_q, stab_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    serr_q, serr_d;
    logic [3:0]    seen_q, seen_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   value_q;
    logic [3:0]    derr_q;
    logic          to_q, to_d;

    logic       onehot;
    logic       same;
    logic       capture;
    logic [3:0] cap_mask;
    logic [3:0] dec;

    function automatic logic [3:0] seg_dec(input logic [6:0] p);
        logic [3:0] r;
        case (p)
            7'b1111110: r = 4'd0;
            7'b0110000: r = 4'd1;
            7'b1101101: r = 4'd2;
            7'b1111001: r = 4'd3;
            7'b0110011: r = 4'd4;
            7'b1011011: r = 4'd5;
            7'b1011111: r = 4'd6;
            7'b1110000: r = 4'd7;
            7'b1111111: r = 4'd8;
            7'b1111011: r = 4'd9;
            default:    r = 4'hF;
        endcase
        return r;
    endfunction

    // Stability tracking on the registered sample pair; blanking never counts.
    always_comb begin
        onehot   = (samp_q[3:0] != 4'b0)
                 && ((samp_q[3:0] & (samp_q[3:0] - 4'd1)) == 4'b0);
        same     = (samp_q == prev_q);
        capture  = onehot && same && (stab_q == STAB_HIT);
        cap_mask = capture ? samp_q[3:0] : 4'b0;
        dec      = seg_dec(samp_q[10:4]);
        stab_d   = SW'(1);
        if (onehot && same)
            stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + SW'(1);
    end

    // Shadow nibble/error write for the captured digit (latest wins).
    always_comb begin
        shadow_d = shadow_q;
        serr_d   = serr_q;
        for (int n = 0; n < 4; n++) begin
            if (capture && samp_q[n]) begin
                shadow_d[4*n +: 4] = dec;
                serr_d[n]          = (dec == 4'hF);
            end
        end
    end

    // Frame collection FSM with capture-reloaded timeout counter.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        tmo_d   = tmo_q;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    seen_d  = cap_mask;
                    tmo_d   = TMO_LOAD;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (capture) begin
                    seen_d = seen_q | cap_mask;
                    tmo_d  = TMO_LOAD;
                    if (seen_d == 4'b1111)
                        state_d = S_PUBLISH;
                end else if (tmo_q == '0) begin
                    seen_d  = 4'b0;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            S_PUBLISH: begin
                seen_d  = cap_mask;
                state_d = capture ? S_COLLECT : S_IDLE;
                if (capture)
                    tmo_d = TMO_LOAD;
            end
            default: begin
                seen_d  = 4'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; outputs load on the edge that enters PUBLISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q   <= '0;
            prev_q   <= '0;
            stab_q   <= SW'(1);
            shadow_q <= '0;
            serr_q   <= '0;
            seen_q   <= '0;
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            value_q  <= '0;
            derr_q   <= '0;
            to_q     <= 1'b0;
        end else begin
            samp_q   <= {seg, dig_sel};
            prev_q   <= samp_q;
            stab_q   <= stab_d;
            shadow_q <= shadow_d;
            serr_q   <= serr_d;
            seen_q   <= seen_d;
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            to_q     <= to_d;
            if (state_d == S_PUBLISH) begin
                value_q <= shadow_d;
                derr_q  <= serr_d;
            end
        end
    end

    assign value       = value_q;
    assign digit_err   = derr_q;
    assign frame_valid = (state_q == S_PUBLISH);
    assign timeout     = to_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scans plus random hold sequences,
// checked by a scoreboard fed from a per-hold reference model.
module tb_seg7_scan_reader;

    localparam int S = 4;
    localparam int T = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        timeout;

    seg7_scan_reader #(.STABLE_CYC(S), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
        .value(value), .digit_err(digit_err),
        .frame_valid(frame_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        logic [15:0] v;
        logic [3:0]  e;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  edge_n = 0;

    logic [6:0]  pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
                              7'b1111001, 7'b0110011, 7'b1011011,
                              7'b1011111, 7'b1110000, 7'b1111111,
                              7'b1111011};
    logic [3:0]  m_nib [4];
    bit          m_err [4];
    logic [3:0]  m_seen = '0;
    int          m_last = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_derr = '0;
    logic [10:0] last_in = '0;

    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic int dec(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (pat[i] == p) return i;
        return -1;
    endfunction

    function automatic int idx_of(input logic [3:0] d);
        for (int i = 0; i < 4; i++)
            if (d[i]) return i;
        return 0;
    endfunction

    task automatic check_to(input int upto);
        ev_t ev;
        if (m_seen != 0 && m_last + T < upto) begin
            ev.is_to = 1'b1; ev.v = m_val; ev.e = m_derr;
            q.push_back(ev);
            m_seen = '0;
        end
    endtask

    task automatic model_cap(input logic [6:0] s, input logic [3:0] d,
                             input int c);
        ev_t ev;
        int i, v;
        i = idx_of(d);
        v = dec(s);
        m_nib[i] = (v < 0) ? 4'hF : 4'(v);
        m_err[i] = (v < 0);
        m_seen[i] = 1'b1;
        m_last = c;
        if (m_seen == 4'hF) begin
            m_val = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            m_derr = {m_err[3], m_err[2], m_err[1], m_err[0]};
            ev.is_to = 1'b0; ev.v = m_val; ev.e = m_derr;
            q.push_back(ev);
            m_seen = '0;
        end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d,
                        input int len);
        int t;
        bit cp;
        t = edge_n + 1;
        cp = (len >= S) && ($countones(d) == 1);
        check_to(cp ? t + S : t + len);
        if (cp) model_cap(s, d, t + S);
        last_in = {s, d};
        seg = s;
        dig_sel = d;
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg = '0;
        dig_sel = '0;
        @(negedge clk);
        rst = 1'b0;
        m_seen = '0; m_val = '0; m_derr = '0; last_in = '0;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_to", 32'(timeout), 32'h0);
    endtask

    // Monitor: pop the next expected event whenever the DUT reports one.
    always @(negedge clk) begin
        if (!rst && (frame_valid || timeout)) begin
            ev_t ev;
            chk("fv_to_exclusive", 32'(frame_valid && timeout), 32'h0);
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got fv=%b to=%b expected none",
                         frame_valid, timeout);
            end else begin
                ev = q.pop_front();
                chk("event_kind", 32'(timeout), 32'(ev.is_to));
                chk("event_value", 32'(value), 32'(ev.v));
                chk("event_err", 32'(digit_err), 32'(ev.e));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  s;
        logic [3:0]  d;
        int          r, len;
        @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);

        // T1 scan 0-3-5-9
        hold(pat[0], 4'b0001, 8);
        hold(pat[3], 4'b0010, 8);
        hold(pat[5], 4'b0100, 8);
        hold(pat[9], 4'b1000, 8);
        hold('0, '0, 6);
        chk("t1_value", 32'(value), 32'h9530);
        chk("t1_err", 32'(digit_err), 32'h0);

        // T2 digit 2 too short, then long idle
        hold(pat[1], 4'b0001, 8);
        hold(pat[2], 4'b0010, 8);
        hold(pat[7], 4'b0100, S - 1);
        hold(pat[4], 4'b1000, 8);
        hold('0, '0, T + 40);
        chk("t2_value", 32'(value), 32'h9530);

        // T3 invalid pattern on digit 1
        hold(pat[8], 4'b0001, 8);
        hold(7'b0000001, 4'b0010, 8);
        hold(pat[6], 4'b0100, 8);
        hold(pat[2], 4'b1000, 8);
        hold('0, '0, 6);
        chk("t3_value", 32'(value), 32'h26F8);
        chk("t3_err", 32'(digit_err), 32'h2);

        // T4 glitching segments on digit 0, then steady "1"
        for (int i = 0; i < 10; i++)
            hold(i[0] ? 7'b1000000 : 7'b0000001, 4'b0001, 1);
        hold(pat[1], 4'b0001, 8);
        hold(pat[4], 4'b0010, 8);
        hold(pat[4], 4'b0100, 8);
        hold(pat[4], 4'b1000, 8);
        hold('0, '0, 6);
        chk("t4_value", 32'(value), 32'h4441);

        // T5 blanking and multi-select between digits
        hold(pat[7], 4'b0001, 8);
        hold(pat[8], 4'b0000, 20);
        hold(pat[6], 4'b0010, 8);
        hold(pat[3], 4'b0011, 20);
        hold(pat[5], 4'b0100, 8);
        hold(pat[9], 4'b0000, 20);
        hold(pat[0], 4'b1000, 8);
        hold('0, '0, 6);
        chk("t5_value", 32'(value), 32'h0567);

        // T6 reset after three digits, then a fresh scan
        hold(pat[2], 4'b0001, 8);
        hold(pat[2], 4'b0010, 8);
        hold(pat[2], 4'b0100, 8);
        hold('0, '0, 2);
        do_reset();
        hold('0, '0, 4);
        hold(pat[6], 4'b0001, 8);
        hold(pat[7], 4'b0010, 8);
        hold(pat[8], 4'b0100, 8);
        hold(pat[9], 4'b1000, 8);
        hold('0, '0, 6);
        chk("t6_value", 32'(value), 32'h9876);

        // Random hold sequences
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(99);
            if (r < 70) begin
                d = 4'b0001 << $urandom_range(3);
                s = ($urandom_range(9) == 0) ? 7'($urandom)
                                             : pat[$urandom_range(9)];
                len = $urandom_range(12, S - 1);
            end else if (r < 85) begin
                d = 4'($urandom);
                s = 7'($urandom);
                len = $urandom_range(S - 1, 1);
            end else begin
                d = ($urandom_range(1) == 0) ? 4'b0000 : 4'b1010;
                s = 7'($urandom);
                len = $urandom_range(20, 1);
            end
            while ($countones(d) == 1 && {s, d} == last_in)
                s = 7'($urandom);
            hold(s, d, len);
        end
        hold('0, '0, T + 40);
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
